pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline stage register; next generation of the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers in the pipelined CPU.
- Carries control word, instruction and PC between stages with valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble (NOP) insertion.
- One instance per stage boundary. The hazard unit drives flush; downstream backpressure drives out_ready.

Parameters:
- CTRL_W, 32, control-signal word width
- INSTR_W, 32, instruction width
- PC_W, 32, program-counter width
- CNT_W, 16, width of performance counters (optional feature only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control word
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- flush  in  1  discard all held entries (branch/exception squash)
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control word; forced to 0 (NOP) when out_valid=0
- out_instr  out  INSTR_W  instruction of head entry
- out_pc  out  PC_W  PC of head entry
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (optional feature)
- flush_cnt  out  CNT_W  flush events that discarded at least one entry (optional feature)

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage: main register (head, drives outputs) and skid register.
- State machine:
  - EMPTY: in_fire -> ONE (main<=in).
  - ONE:
    - in_fire & out_fire -> ONE (main<=in).
    - in_fire & !out_fire -> TWO (skid<=in).
    - !in_fire & out_fire -> EMPTY.
    - Otherwise stay.
  - TWO: in_ready=0, so no in_fire. out_fire -> ONE (main<=skid). Otherwise stay.
- Outputs per state:
  - out_valid = 1 in ONE or TWO.
  - in_ready = 1 in EMPTY or ONE; registered (next-state != TWO).
- Timing:
  - Latency 1 cycle from in_fire to out_valid when EMPTY.
  - Throughput 1 entry/cycle with no backpressure.
  - Order strictly FIFO.
- Payload stability: while out_valid=1 & out_ready=0, out_ctrl/out_instr/out_pc hold stable.
- Bubble: when out_valid=0, out_ctrl=0. out_instr and out_pc hold their last values (0 after reset).
- Flush:
  - Next state EMPTY; both entries discarded.
  - An in_fire in the same cycle is dropped.
  - in_ready=1 the following cycle.
  - Priority: reset > flush > normal transfer.
- Reset (sync, active-high):
  - State EMPTY; main and skid cleared to 0.
  - out_valid=0, out_ctrl=0, out_instr=0, out_pc=0, in_ready=1, counters=0.
  - Reset mid-transfer discards all entries; in_ready=1 the next cycle.
- No combinational path from out_ready to in_ready.
- No arithmetic on payload; widths pass through unchanged.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments on flush while state != EMPTY.
  - Both saturate at 2^CNT_W-1; reset to 0. Reset during flush does not count.
- Undefined: stall_cnt and flush_cnt tied to 0; no counter flops.

Decomposition:
- Shared package pipe_pkg:
  - State enum: PS_EMPTY, PS_ONE, PS_TWO.
  - CTRL_NOP constant (all zeros).
  - Default width constants: CTRL_W_DEF, INSTR_W_DEF, PC_W_DEF.
- Sub-module pipe_sat_counter:
  - Parameter WIDTH; inputs clk, reset, inc; output count.
  - Saturating; instantiated twice under PIPE_STAGE_REG_PERF_EN.

Test Plan:
- Reset: reset=1 for 2 cycles -> out_valid=0, out_ctrl=0, out_pc=0, in_ready=1, counters 0.
- Streaming:
  - Stimulus: in_valid=1, out_ready=1, in_pc=0,4,8,12 on consecutive cycles.
  - Response: out_pc=0,4,8,12 one cycle later each; in_ready stays 1; no gaps.
- Backpressure / skid:
  - Stimulus: out_ready=0 while sending pc=0x10 then 0x14.
  - Response: in_ready=0 after 2nd accept; out_pc holds 0x10.
  - Then raise out_ready: 0x10, then 0x14; in_ready=1 one cycle after first out_fire.
- Flush while TWO with in_valid=1 (pc=0x20):
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
  - 0x20 never appears at output; flush_cnt=1 (PERF_EN).
- Bubble: in_valid=0 for 3 cycles after pc=0x30 drains -> out_valid=0 and out_ctrl=0 each cycle; out_pc holds 0x30.
- Stall counter (PERF_EN, CNT_W=4):
  - Stimulus: hold out_ready=0 with valid entry for 20 cycles.
  - Response: stall_cnt saturates at 15.
  - Without macro: stall_cnt stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int CTRL_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF    = 32;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with 2-entry skid buffer, flush and NOP bubbles.
// Optional performance counters enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    pipe_state_t        state;
    pipe_state_t        state_nxt;
    logic               in_fire;
    logic               out_fire;

    logic [CTRL_W-1:0]  main_ctrl;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    main_pc;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state != PS_EMPTY);
    assign out_fire  = out_valid & out_ready;

    // Head entry drives the outputs; control is masked to a NOP during bubbles.
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_W'(CTRL_NOP);
    assign out_instr = main_instr;
    assign out_pc    = main_pc;

    always_comb begin
        state_nxt = state;
        case (state)
            PS_EMPTY: if (in_fire) state_nxt = PS_ONE;
            PS_ONE: begin
                if (in_fire && !out_fire)      state_nxt = PS_TWO;
                else if (!in_fire && out_fire) state_nxt = PS_EMPTY;
            end
            PS_TWO:   if (out_fire) state_nxt = PS_ONE;
            default:  state_nxt = PS_EMPTY;
        endcase
        if (flush) state_nxt = PS_EMPTY;
    end

    // in_ready is a flop decoded from next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PS_EMPTY;
            in_ready   <= 1'b1;
            main_ctrl  <= '0;
            main_instr <= '0;
            main_pc    <= '0;
            skid_ctrl  <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != PS_TWO);
            if (!flush) begin
                case (state)
                    PS_EMPTY: begin
                        if (in_fire) begin
                            main_ctrl  <= in_ctrl;
                            main_instr <= in_instr;
                            main_pc    <= in_pc;
                        end
                    end
                    PS_ONE: begin
                        if (in_fire && out_fire) begin
                            main_ctrl  <= in_ctrl;
                            main_instr <= in_instr;
                            main_pc    <= in_pc;
                        end else if (in_fire) begin
                            skid_ctrl  <= in_ctrl;
                            skid_instr <= in_instr;
                            skid_pc    <= in_pc;
                        end
                    end
                    PS_TWO: begin
                        if (out_fire) begin
                            main_ctrl  <= skid_ctrl;
                            main_instr <= skid_instr;
                            main_pc    <= skid_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & (state != PS_EMPTY)),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed test-plan phases followed by random traffic.
module tb_pipe_stage_reg;

    localparam int CW = 32;
    localparam int IW = 32;
    localparam int PW = 32;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [IW-1:0] in_instr = '0;
    logic [PW-1:0] in_pc = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ctrl;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    entry_t exp_q[$];
    entry_t shown = '0;
    int     stall_m = 0;
    int     flush_m = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W  (CW),
        .INSTR_W (IW),
        .PC_W    (PW),
        .CNT_W   (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a two-deep FIFO, checked and advanced on every falling edge.
    always @(negedge clk) begin
        int  sz;
        bit  pop_m;
        bit  push_m;
        sz = exp_q.size();
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        chk("in_ready", 32'(in_ready), 32'(sz < 2));
        if (sz > 0) begin
            chk("out_ctrl", out_ctrl, exp_q[0].ctrl);
            chk("out_instr", out_instr, exp_q[0].instr);
            chk("out_pc", out_pc, exp_q[0].pc);
            shown = exp_q[0];
        end else begin
            chk("bubble_ctrl", out_ctrl, 32'd0);
            chk("bubble_instr", out_instr, shown.instr);
            chk("bubble_pc", out_pc, shown.pc);
        end
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        chk("flush_cnt", 32'(flush_cnt), 32'(flush_m));

        if (reset) begin
            exp_q.delete();
            shown   = '0;
            stall_m = 0;
            flush_m = 0;
        end else begin
`ifdef PIPE_STAGE_REG_PERF_EN
            if (sz > 0 && !out_ready && stall_m < SAT) stall_m++;
            if (flush && sz > 0 && flush_m < SAT) flush_m++;
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                pop_m  = (sz > 0) && out_ready;
                push_m = in_valid && (sz < 2);
                if (pop_m) void'(exp_q.pop_front());
                if (push_m) exp_q.push_back('{ctrl: in_ctrl, instr: in_instr, pc: in_pc});
            end
        end
    end

    task automatic step(input logic v, input logic [PW-1:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_ctrl   = $urandom;
        in_instr  = $urandom;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held for two cycles
        reset = 1'b1;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        reset = 1'b0;

        // streaming with no backpressure
        for (int i = 0; i < 4; i++) step(1, PW'(i * 4), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // backpressure into the skid register, then drain
        step(1, 'h10, 0, 0);
        step(1, 'h14, 0, 0);
        step(1, 'h99, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // flush while full with a new entry offered
        step(1, 'h40, 0, 0);
        step(1, 'h44, 0, 0);
        step(1, 'h20, 0, 1);
        step(0, 0, 1, 0);

        // flush while holding one entry drops the simultaneous accept
        step(1, 'h48, 0, 0);
        step(1, 'h20, 1, 1);
        step(0, 0, 1, 0);

        // bubbles after a single entry drains
        step(1, 'h30, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // long stall to saturate the stall counter
        step(1, 'h50, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 3) != 0), PW'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        reset = 1'b0;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
